// File: rtl/mul_exec_stage.sv
// ---------------------------------------------------------------------------
// mul_exec_stage
//
// Two-stage pipelined RV32M multiply execution unit (MUL, MULH, MULHSU,
// MULHU). It sits between issue/dispatch and the writeback arbiter.
//
// Operation:
//   S1 captures a decoded op from the issue side.
//   Between S1 and S2 the signed/unsigned 64-bit product is formed.
//   S2 holds the product and the op's metadata. The low or high word is
//   selected from S2 and driven to writeback.
//
// Both sides use a valid/ready handshake. Backpressure is supported
// through the whole pipe, and flush discards every in-flight op.
//
// Parameters:
//   XLEN   operand/result width (only 32 is supported)
//   TAG_W  destination register tag width
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   flush      drop all in-flight ops (mispredict / trap)
//   in_valid   upstream presents an op
//   in_ready   stage can accept an op this cycle
//   in_funct3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 1xx illegal
//   in_rs1     operand a (multiplicand)
//   in_rs2     operand b (multiplier)
//   in_tag     destination register tag
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   selected 32-bit result
//   out_tag    tag travelling with the result
//   out_err    op carried an illegal funct3
// ---------------------------------------------------------------------------
module mul_exec_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011
    } mul_op_t;

    localparam logic [XLEN-1:0]   ONE_X = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_P = {{(2*XLEN-1){1'b0}}, 1'b1};

    // S1 registers: the op exactly as issued
    logic             s1_valid;
    logic [2:0]       s1_funct3;
    logic [XLEN-1:0]  s1_rs1;
    logic [XLEN-1:0]  s1_rs2;
    logic [TAG_W-1:0] s1_tag;

    // S2 registers: full product plus the metadata needed for selection
    logic              s2_valid;
    logic [2:0]        s2_funct3;
    logic [2*XLEN-1:0] s2_product;
    logic [TAG_W-1:0]  s2_tag;

    logic s2_adv;
    logic s1_adv;

    // S2 may move when it is empty or its result leaves this cycle. S1
    // may move when it is empty or S2 makes room. in_ready depends only on
    // state and out_ready, never on in_valid.
    assign s2_adv   = ~s2_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = s1_adv;

    // Signedness per op: rs1 is signed for MULH and MULHSU, rs2 only for
    // MULH. Illegal ops fall into the unsigned path; their result is
    // discarded at output selection anyway.
    logic rs1_signed;
    logic rs2_signed;
    logic rs1_neg;
    logic rs2_neg;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] product;

    always_comb begin
        rs1_signed = (s1_funct3 == OP_MULH) || (s1_funct3 == OP_MULHSU);
        rs2_signed = (s1_funct3 == OP_MULH);
        rs1_neg    = rs1_signed & s1_rs1[XLEN-1];
        rs2_neg    = rs2_signed & s1_rs2[XLEN-1];
    end

    // Multiply magnitudes, then restore the sign. The magnitude of the
    // most negative value (0x80000000) is 2^31. That value is
    // representable as an unsigned XLEN number, so MULH min*min comes out
    // right without any special case.
    always_comb begin
        mag_a    = rs1_neg ? (~s1_rs1 + ONE_X) : s1_rs1;
        mag_b    = rs2_neg ? (~s1_rs2 + ONE_X) : s1_rs2;
        prod_mag = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
        product  = (rs1_neg ^ rs2_neg) ? (~prod_mag + ONE_P) : prod_mag;
    end

    // Pipeline state.
    // Flush overrides every transfer, including an input offered in the
    // same cycle. Payload registers load only when a valid op moves in.
    // That keeps the outputs frozen during a stall and keeps power down on
    // bubbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_funct3  <= '0;
            s1_rs1     <= '0;
            s1_rs2     <= '0;
            s1_tag     <= '0;
            s2_valid   <= 1'b0;
            s2_funct3  <= '0;
            s2_product <= '0;
            s2_tag     <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_funct3  <= s1_funct3;
                    s2_product <= product;
                    s2_tag     <= s1_tag;
                end
            end
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_funct3 <= in_funct3;
                    s1_rs1    <= in_rs1;
                    s1_rs2    <= in_rs2;
                    s1_tag    <= in_tag;
                end
            end
        end
    end

    // Output word selection.
    // MUL returns the low half and the MULH* variants return the high
    // half. Illegal ops return zero and are flagged with out_err.
    always_comb begin
        out_data = '0;
        case (s2_funct3)
            OP_MUL:                       out_data = s2_product[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: out_data = s2_product[2*XLEN-1:XLEN];
            default:                      out_data = '0;
        endcase
    end

    assign out_valid = s2_valid;
    assign out_tag   = s2_tag;
    assign out_err   = s2_funct3[2];

endmodule
